// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU flag/writeback stage: ARM condition codes,
// NZCV bit positions and the writeback entry layout.
package alu_wb_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_RD_W   = 4;

  typedef struct packed {
    logic [WB_DATA_W-1:0] result;
    logic [WB_RD_W-1:0]   rd;
    logic                 write_rd;
  } wb_entry_t;

endpackage

// File: rtl/alu_wb_cond_eval.sv
// ARM condition-field evaluator: decides whether an instruction retires
// given the currently committed NZCV flags.
module alu_cond_eval
  import alu_wb_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_writeback.sv
// Execute-stage output register: condition check, NZCV commit and a 2-entry
// skid buffer toward writeback. Optional counters under ALU_WB_PERF_EN.
module alu_flag_writeback
  import alu_wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_negative,
  input  logic              in_zero,
  input  logic              in_carry,
  input  logic              in_overflow,
  input  logic [3:0]        in_cond,
  input  logic              in_set_flags,
  input  logic              in_write_rd,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_write_rd,
  output logic [3:0]        flags_nzcv
`ifdef ALU_WB_PERF_EN
  ,
  output logic [15:0]       retired_count,
  output logic [15:0]       squashed_count
`endif
);

  // Same field order as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              write_rd;
  } entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_TWO
  } buf_state_t;

  buf_state_t state, state_next;
  entry_t     main_q, skid_q, in_entry;
  logic       accept, pass, enq, pop;
  logic       load_main_new, load_main_skid, load_skid;

  alu_cond_eval u_cond_eval (
    .cond (in_cond),
    .nzcv (flags_nzcv),
    .pass (pass)
  );

  assign in_entry  = '{result: in_result, rd: in_rd, write_rd: in_write_rd};
  assign accept    = in_valid & in_ready;
  assign enq       = accept & pass & !flush;
  assign out_valid = (state != BUF_EMPTY);
  assign pop       = out_valid & out_ready;

  assign out_result   = main_q.result;
  assign out_rd       = main_q.rd;
  assign out_write_rd = main_q.write_rd;

  always_comb begin
    state_next     = state;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (enq) begin
            state_next    = BUF_ONE;
            load_main_new = 1'b1;
          end
        end
        BUF_ONE: begin
          // Pop plus accept refills main directly; skid stays empty.
          if (pop && enq) begin
            load_main_new = 1'b1;
          end else if (pop) begin
            state_next = BUF_EMPTY;
          end else if (enq) begin
            state_next = BUF_TWO;
            load_skid  = 1'b1;
          end
        end
        BUF_TWO: begin
          if (pop) begin
            load_main_skid = 1'b1;
            if (enq) load_skid = 1'b1;
            else     state_next = BUF_ONE;
          end
        end
        default: state_next = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BUF_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != BUF_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_new)       main_q <= in_entry;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_nzcv <= '0;
    end else if (enq && in_set_flags) begin
      flags_nzcv[FLAG_N] <= in_negative;
      flags_nzcv[FLAG_Z] <= in_zero;
      flags_nzcv[FLAG_C] <= in_carry;
      flags_nzcv[FLAG_V] <= in_overflow;
    end
  end

`ifdef ALU_WB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count  <= '0;
      squashed_count <= '0;
    end else begin
      if (pop && (retired_count != '1))
        retired_count <= retired_count + 16'd1;
      if (accept && !pass && !flush && (squashed_count != '1))
        squashed_count <= squashed_count + 16'd1;
    end
  end
`endif

endmodule
